// File: rtl/btn_event_pkg.sv
// Shared constants and types for the button-event core: register addresses,
// hold-counter width and the per-channel event bundle.
package btn_event_pkg;

  localparam logic [4:0] ADDR_LEVEL = 5'd0;
  localparam logic [4:0] ADDR_RISE  = 5'd1;
  localparam logic [4:0] ADDR_FALL  = 5'd2;
  localparam logic [4:0] ADDR_IE    = 5'd3;
  localparam logic [4:0] ADDR_LONG  = 5'd4;
  localparam logic [4:0] ADDR_LPTHR = 5'd5;

  localparam int LP_CNT_W = 8;

  typedef struct packed {
    logic rise;
    logic fall;
    logic long_press;
  } btn_ev_t;

endpackage

// File: rtl/btn_event_chan.sv
// One button channel: edge detect, optional hold counter and sticky event bits.
// Long-press logic is built only when BTN_EVENT_LONG_PRESS_EN is defined.
module btn_event_chan
  import btn_event_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                db_in,
  input  logic                primed,
  input  logic                tick,
  input  logic [LP_CNT_W-1:0] lp_thr,
  input  btn_ev_t             w1c,
  output btn_ev_t             sticky
);

  logic    prev;
  logic    long_ev;
  btn_ev_t ev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= db_in;
  end

`ifdef BTN_EVENT_LONG_PRESS_EN
  localparam logic [LP_CNT_W-1:0] CNT_ONE = LP_CNT_W'(1);

  logic [LP_CNT_W-1:0] hold_cnt;
  logic                cnt_step;

  // The counter only advances below saturation, so a fire needs a real increment.
  assign cnt_step = tick & db_in & (hold_cnt != '1);
  assign long_ev  = cnt_step & (lp_thr != '0) & ((hold_cnt + CNT_ONE) == lp_thr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         hold_cnt <= '0;
    else if (!db_in)   hold_cnt <= '0;
    else if (cnt_step) hold_cnt <= hold_cnt + CNT_ONE;
  end
`else
  logic unused_lp;
  assign unused_lp = ^{tick, lp_thr};
  assign long_ev   = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ev            = '0;
    ev.rise       = primed & db_in & ~prev;
    ev.fall       = primed & ~db_in & prev;
    ev.long_press = long_ev;
  end

  // A new event always beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky <= '0;
    else       sticky <= (ev | sticky) & ~(w1c & ~ev);
  end

endmodule

// File: rtl/btn_event_core.sv
// Memory-mapped button-event core: W channels, sticky rise/fall/long events,
// maskable registered irq. Long-press support gated by BTN_EVENT_LONG_PRESS_EN.
module btn_event_core
  import btn_event_pkg::*;
#(
  parameter int W      = 8,
  parameter int LP_RST = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  db_in,
  input  logic          tick,
  output logic          irq
);

`ifdef BTN_EVENT_LONG_PRESS_EN
  localparam int IE_W = 3 * W;
`else
  localparam int IE_W = 2 * W;
`endif

  logic                wr_en;
  logic                primed;
  logic                irq_next;
  logic [IE_W-1:0]     ie;
  logic [LP_CNT_W-1:0] lp_thr;
  logic [W-1:0]        rise_v, fall_v, long_v;

  assign wr_en = cs & write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) primed <= 1'b0;
    else       primed <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          ie <= '0;
    else if (wr_en && addr == ADDR_IE)  ie <= wr_data[IE_W-1:0];
  end

`ifdef BTN_EVENT_LONG_PRESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            lp_thr <= LP_CNT_W'(LP_RST);
    else if (wr_en && addr == ADDR_LPTHR) lp_thr <= wr_data[LP_CNT_W-1:0];
  end

  logic unused_top;
  assign unused_top = ^{read, wr_data};
`else
  localparam logic [LP_CNT_W-1:0] LP_RST_V = LP_CNT_W'(LP_RST);

  assign lp_thr = '0;

  logic unused_top;
  assign unused_top = ^{read, wr_data, long_v, LP_RST_V};
`endif

  for (genvar i = 0; i < W; i++) begin : g_chan
    btn_ev_t w1c;
    btn_ev_t ev_s;

    assign w1c.rise       = wr_en & (addr == ADDR_RISE) & wr_data[i];
    assign w1c.fall       = wr_en & (addr == ADDR_FALL) & wr_data[i];
    assign w1c.long_press = wr_en & (addr == ADDR_LONG) & wr_data[i];

    btn_event_chan u_chan (
      .clk    (clk),
      .reset  (reset),
      .db_in  (db_in[i]),
      .primed (primed),
      .tick   (tick),
      .lp_thr (lp_thr),
      .w1c    (w1c),
      .sticky (ev_s)
    );

    assign rise_v[i] = ev_s.rise;
    assign fall_v[i] = ev_s.fall;
    assign long_v[i] = ev_s.long_press;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_LEVEL: rd_data[W-1:0]        = db_in;
      ADDR_RISE:  rd_data[W-1:0]        = rise_v;
      ADDR_FALL:  rd_data[W-1:0]        = fall_v;
      ADDR_IE:    rd_data[IE_W-1:0]     = ie;
`ifdef BTN_EVENT_LONG_PRESS_EN
      ADDR_LONG:  rd_data[W-1:0]        = long_v;
      ADDR_LPTHR: rd_data[LP_CNT_W-1:0] = lp_thr;
`endif
      default:    rd_data               = '0;
    endcase
  end

  always_comb begin
    irq_next = (|(rise_v & ie[W-1:0])) | (|(fall_v & ie[2*W-1:W]));
`ifdef BTN_EVENT_LONG_PRESS_EN
    irq_next = irq_next | (|(long_v & ie[3*W-1:2*W]));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_next;
  end

endmodule

// File: tb/tb_btn_event_core.sv
// Self-checking bench for btn_event_core: directed scenarios plus random traffic
// compared every cycle against a behavioural register-level model.
module tb_btn_event_core;
  import btn_event_pkg::*;

  localparam int W      = 8;
  localparam int LP_RST = 100;
`ifdef BTN_EVENT_LONG_PRESS_EN
  localparam int IE_W = 3 * W;
`else
  localparam int IE_W = 2 * W;
`endif
  localparam logic [31:0] IE_MASK = (32'd1 << IE_W) - 32'd1;

  logic         clk = 1'b0;
  logic         reset, cs, read, write, tick, irq;
  logic [4:0]   addr;
  logic [31:0]  wr_data, rd_data;
  logic [W-1:0] db_in;

  always #5 clk = ~clk;

  btn_event_core #(.W(W), .LP_RST(LP_RST)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .db_in   (db_in),
    .tick    (tick),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and per-channel hold times as plain integers.
  logic [W-1:0] m_prev, m_rise, m_fall, m_long;
  logic [31:0]  m_ie;
  bit           m_primed, m_irq;
  int           m_thr;
  int           m_cnt [W];

  task automatic m_reset();
    m_prev = '0; m_rise = '0; m_fall = '0; m_long = '0;
    m_ie = '0; m_primed = 0; m_irq = 0; m_thr = LP_RST;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      ADDR_LEVEL: r = 32'(db_in);
      ADDR_RISE:  r = 32'(m_rise);
      ADDR_FALL:  r = 32'(m_fall);
      ADDR_IE:    r = m_ie;
`ifdef BTN_EVENT_LONG_PRESS_EN
      ADDR_LONG:  r = 32'(m_long);
      ADDR_LPTHR: r = 32'(m_thr);
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic m_edge();
    logic [W-1:0] n_rise, n_fall, n_long;
    bit wr, er, ef, el, n_irq;
    wr     = cs && write;
    n_rise = m_rise; n_fall = m_fall; n_long = m_long;
    n_irq  = (|(m_rise & m_ie[W-1:0])) || (|(m_fall & m_ie[2*W-1:W])) ||
             (|(m_long & m_ie[3*W-1:2*W]));
    for (int i = 0; i < W; i++) begin
      er = m_primed && db_in[i] && !m_prev[i];
      ef = m_primed && !db_in[i] && m_prev[i];
      el = 0;
`ifdef BTN_EVENT_LONG_PRESS_EN
      if (!db_in[i]) m_cnt[i] = 0;
      else if (tick && m_cnt[i] < 255) begin
        m_cnt[i]++;
        el = (m_thr != 0) && (m_cnt[i] == m_thr);
      end
`endif
      if (er) n_rise[i] = 1'b1;
      else if (wr && addr == ADDR_RISE && wr_data[i]) n_rise[i] = 1'b0;
      if (ef) n_fall[i] = 1'b1;
      else if (wr && addr == ADDR_FALL && wr_data[i]) n_fall[i] = 1'b0;
      if (el) n_long[i] = 1'b1;
      else if (wr && addr == ADDR_LONG && wr_data[i]) n_long[i] = 1'b0;
    end
    if (wr && addr == ADDR_IE) m_ie = wr_data & IE_MASK;
`ifdef BTN_EVENT_LONG_PRESS_EN
    if (wr && addr == ADDR_LPTHR) m_thr = int'(wr_data[7:0]);
`endif
    m_rise = n_rise; m_fall = n_fall; m_long = n_long;
    m_prev = db_in; m_primed = 1; m_irq = n_irq;
  endtask

  // One clock: drive, step the model, take the edge, compare irq and rd_data.
  task automatic step(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d,
                      input logic [W-1:0] db, input bit t);
    cs = c; write = w; read = c & ~w; addr = a; wr_data = d; db_in = db; tick = t;
    m_edge();
    @(posedge clk); #1;
    check("irq", 32'(irq), 32'(m_irq));
    check($sformatf("rd_a%0d", a), rd_data, m_read(a));
  endtask

  task automatic rd(input logic [4:0] a);            step(1, 0, a, '0, db_in, 0); endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 1, a, d, db_in, 0); endtask
  task automatic set_db(input logic [W-1:0] db);     step(0, 0, ADDR_LEVEL, '0, db, 0); endtask
  task automatic tk_rd(input logic [4:0] a);         step(1, 0, a, '0, db_in, 1); endtask

  task automatic apply_reset(input logic [W-1:0] db);
    reset = 1; cs = 0; write = 0; read = 0; wr_data = '0; db_in = db; tick = 0;
    m_reset();
    addr = ADDR_RISE; #1;
    check("rst_rise", rd_data, 32'h0);
    addr = ADDR_LONG; #1;
    check("rst_long", rd_data, 32'h0);
    addr = ADDR_IE; #1;
    check("rst_ie", rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
  endtask

  task automatic run_random(input int n);
    logic [W-1:0] db;
    logic [4:0]   a;
    logic [31:0]  d;
    bit           c, w, t;
    for (int k = 0; k < n; k++) begin
      db = db_in;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 15) == 0) db[b] = ~db[b];
      c = ($urandom_range(0, 3) != 0);
      w = c && ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      d = $urandom;
      if (a == ADDR_LPTHR) d = 32'($urandom_range(0, 6));
      t = ($urandom_range(0, 3) == 0);
      step(c, w, a, d, db, t);
    end
  endtask

  initial begin
    // Power-up with bit0 already high: no event may appear.
    apply_reset(8'h01);
    repeat (10) rd(ADDR_RISE);
    check("pwr_rise", rd_data, 32'h0);
    check("pwr_irq", 32'(irq), 32'h0);

    // Rise on bit0 with rise enable, then W1C.
    wr(ADDR_IE, 32'h1);
    set_db(8'h00);
    wr(ADDR_FALL, 32'hFF);
    set_db(8'h01);
    check("irq_not_yet", 32'(irq), 32'h0);
    rd(ADDR_RISE);
    check("rise_b0", rd_data, 32'h1);
    check("irq_rise", 32'(irq), 32'h1);
    wr(ADDR_RISE, 32'h1);
    check("w1c_rise", rd_data, 32'h0);
    check("irq_lag", 32'(irq), 32'h1);
    rd(ADDR_RISE);
    check("irq_drop", 32'(irq), 32'h0);

    // Fall on bit3 with fall enable; W1C racing a new fall keeps the bit.
    wr(ADDR_IE, 32'h800);
    set_db(8'h09);
    rd(ADDR_FALL);
    set_db(8'h01);
    rd(ADDR_FALL);
    check("fall_b3", rd_data, 32'h8);
    check("irq_fall", 32'(irq), 32'h1);
    set_db(8'h09);
    step(1, 1, ADDR_FALL, 32'h8, 8'h01, 0);
    check("w1c_vs_fall", rd_data, 32'h8);
    wr(ADDR_FALL, 32'h8);
    check("fall_clr", rd_data, 32'h0);

`ifdef BTN_EVENT_LONG_PRESS_EN
    wr(ADDR_LPTHR, 32'd3);
    wr(ADDR_IE, 32'h4_0000);
    set_db(8'h05);
    for (int t = 1; t <= 5; t++) begin
      tk_rd(ADDR_LONG);
      check($sformatf("long_t%0d", t), rd_data, (t >= 3) ? 32'h4 : 32'h0);
    end
    wr(ADDR_LONG, 32'h4);
    tk_rd(ADDR_LONG);
    check("long_once", rd_data, 32'h0);
    set_db(8'h01);
    set_db(8'h05);
    repeat (3) tk_rd(ADDR_LONG);
    check("long_rearm", rd_data, 32'h4);
    wr(ADDR_LONG, 32'h4);
    wr(ADDR_LPTHR, 32'd0);
    set_db(8'h01);
    set_db(8'h05);
    repeat (5) tk_rd(ADDR_LONG);
    check("long_thr0", rd_data, 32'h0);
    wr(ADDR_LPTHR, 32'd3);
    tk_rd(ADDR_LONG);
    check("long_thr_past", rd_data, 32'h0);
    wr(ADDR_LPTHR, 32'd7);
    tk_rd(ADDR_LONG);
    check("long_thr_raise", rd_data, 32'h4);
`else
    wr(ADDR_LONG, 32'hFF);
    rd(ADDR_LONG);
    check("long_absent", rd_data, 32'h0);
    wr(ADDR_LPTHR, 32'hFF);
    rd(ADDR_LPTHR);
    check("lpthr_absent", rd_data, 32'h0);
`endif

    // Reset in the middle of a press, then the primed window after release.
    apply_reset(8'h05);
    rd(ADDR_RISE);
    check("post_rst_rise", rd_data, 32'h0);

    // Events with everything masked, then unmask.
    wr(ADDR_IE, 32'h0);
    set_db(8'h00);
    set_db(8'hFF);
    set_db(8'h00);
    rd(ADDR_RISE);
    check("rise_all", rd_data, 32'hFF);
    rd(ADDR_FALL);
    check("fall_all", rd_data, 32'hFF);
    check("irq_masked", 32'(irq), 32'h0);
    wr(ADDR_IE, 32'hFFFF_FFFF);
    rd(ADDR_IE);
    check("irq_unmask", 32'(irq), 32'h1);
    check("ie_mask", rd_data, IE_MASK);
    rd(ADDR_RISE);
    check("no_clear", rd_data, 32'hFF);
    set_db(8'hA5);
    check("level", rd_data, 32'hA5);
    wr(5'd7, 32'hFFFF_FFFF);
    rd(5'd7);
    check("addr7", rd_data, 32'h0);

    wr(ADDR_RISE, 32'hFF);
    wr(ADDR_FALL, 32'hFF);
    wr(ADDR_LONG, 32'hFF);
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
